vsa_mem_responder: RTL and testbench
====================================

// Module: vsa_mem_responder
// PURPOSE
//  Memory-side responder for the 12-bit very-simple-architecture CPU: serves the CPU's
//  instruction fetch port (PC -> instruction) and its data port (ALUOutput/datain/dataout/wr).
//  Holds a 32x12 instruction store and a 32x5 data store.
//  A LOAD/RUN mode FSM lets a host stream a program into the instruction store over a
//  valid/ready handshake before the CPU executes.
// PARAMETERS
//  NOP_WORD   12'h600  word driven on instruction while not RUN (ALUop ADD R0,R0->R0)
//  CNT_W      8        width of the saturating data-write counter
// PORTS
//  clock        in   1      master clock, all state updates on posedge
//  reset_n      in   1      synchronous, active-low reset
//  PC           in   5      CPU instruction address
//  instruction  out  12     registered instruction word to CPU
//  ALUOutput    in   5      CPU data address
//  datain       out  5      read data to CPU (combinational from data store)
//  dataout      in   5      write data from CPU
//  wr           in   1      CPU data write strobe
//  load_valid   in   1      host program word valid
//  load_ready   out  1      responder accepts program word
//  load_data    in   12     program word
//  load_last    in   1      qualifies final program word (sampled with valid&ready)
//  running      out  1      1 in RUN mode
//  wr_count     out  CNT_W  number of accepted CPU data writes, saturating
// BEHAVIOUR
//  Clock/reset (already decided): one clock, clock; reset is synchronous and active-low,
//   reset_n.
//  Reset (reset_n=0 at posedge):
//   - state=LOAD, load pointer=0.
//   - All 32 imem entries=NOP_WORD; all 32 dmem entries=0.
//   - instruction=NOP_WORD, wr_count=0, running=0.
//   - Reset asserted mid-load or mid-run aborts everything and restarts this way.
//  FSM:
//   - LOAD: load_ready=1. On valid&ready, imem[ptr]<=load_data and ptr<=ptr+1.
//     Go to RUN if load_last=1 or ptr==31 (pointer never wraps into a second pass).
//   - RUN: load_ready=0 and load_valid is ignored. RUN is left only by reset.
//  Instruction port:
//   - RUN: each posedge, instruction<=imem[PC] (1-cycle latency). The CPU holds PC stable
//     >=2 cycles before sampling in IF.
//   - LOAD: instruction<=NOP_WORD.
//   - The first RUN-cycle fetch reads imem[PC] after the final load write (write-first
//     across the mode edge).
//  Data port:
//   - datain=dmem[ALUOutput], combinational (the CPU samples one cycle after driving the
//     address).
//   - RUN and wr=1 at posedge: dmem[ALUOutput]<=dataout; wr_count+1, saturating at
//     2^CNT_W-1.
//   - A same-cycle read of the written address shows the old value until the edge.
//   - wr in LOAD is ignored: no store, no count.
//  running = (state==RUN); load_ready = (state==LOAD); both registered-state decodes.
//  Addresses are 5-bit and cover the full stores, so there is no out-of-range case.
// TESTING
//  1 Reset: reset_n=0 one cycle -> instruction=12'h600, datain=0 at any address,
//    wr_count=0, load_ready=1, running=0.
//  2 Load 3 words (12'h801, 12'h212, 12'h600, last on 3rd) -> running=1 next cycle;
//    PC=1 -> instruction=12'h212 one cycle later; PC=3 -> 12'h600.
//  3 Load with valid toggling and 32 words, load_last=0 -> RUN entered after 32nd accept;
//    33rd valid ignored; imem[0] unchanged.
//  4 RUN, ALUOutput=5, dataout=5'h1A, wr=1 one cycle -> datain=5'h00 before the edge,
//    5'h1A after; wr_count=1.
//  5 wr=1 during LOAD with ALUOutput=7, dataout=5'h0F -> dmem[7] stays 0, wr_count=0.
//  6 In RUN, 300 writes -> wr_count saturates at 8'hFF; reset_n=0 mid-run -> LOAD,
//    memories cleared, wr_count=0.

Source files
------------

// File: rtl/vsa_mem_responder.sv
// vsa_mem_responder
//   Memory-side responder for the 12-bit very-simple-architecture CPU. It holds a
//   32x12 instruction store and a 32x5 data store. A LOAD/RUN mode machine lets a
//   host stream a program into the instruction store before the CPU executes.
//
// Ports
//   clock        master clock, all state updates on posedge
//   reset_n      synchronous active-low reset
//   PC           CPU instruction address
//   instruction  registered instruction word (NOP_WORD while loading)
//   ALUOutput    CPU data address
//   datain       read data to CPU, combinational from the data store
//   dataout      write data from CPU
//   wr           CPU data write strobe (ignored while loading)
//   load_valid   host program word valid
//   load_ready   responder accepts a program word (LOAD mode)
//   load_data    host program word
//   load_last    marks the final program word
//   running      high in RUN mode
//   wr_count     saturating count of accepted CPU data writes
module vsa_mem_responder #(
  parameter logic [11:0] NOP_WORD = 12'h600,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       PC,
  output logic [11:0]      instruction,
  input  logic [4:0]       ALUOutput,
  output logic [4:0]       datain,
  input  logic [4:0]       dataout,
  input  logic             wr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [11:0]      load_data,
  input  logic             load_last,
  output logic             running,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned Depth = 32;

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e           state_q, state_d;
  logic [4:0]       load_ptr_q;
  logic [11:0]      imem_q [Depth];
  logic [4:0]       dmem_q [Depth];
  logic [11:0]      instruction_q;
  logic [CNT_W-1:0] wr_count_q;

  logic load_accept;
  logic data_write;

  assign load_accept = (state_q == StLoad) && load_valid;
  assign data_write  = (state_q == StRun) && wr;

  // The pointer reaching the last entry ends the load even without load_last, so a
  // second pass can never overwrite the start of the program.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: if (load_accept && (load_last || (load_ptr_q == 5'd31))) state_d = StRun;
      StRun:  state_d = StRun;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StLoad;
      load_ptr_q <= 5'd0;
    end else begin
      state_q <= state_d;
      if (load_accept) begin
        load_ptr_q <= load_ptr_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        imem_q[i] <= NOP_WORD;
      end
    end else if (load_accept) begin
      imem_q[load_ptr_q] <= load_data;
    end
  end

  // The final load write lands on the same edge that enters RUN, so the first RUN
  // fetch one edge later already sees it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      instruction_q <= NOP_WORD;
    end else if (state_q == StRun) begin
      instruction_q <= imem_q[PC];
    end else begin
      instruction_q <= NOP_WORD;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        dmem_q[i] <= 5'd0;
      end
    end else if (data_write) begin
      dmem_q[ALUOutput] <= dataout;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_count_q <= '0;
    end else if (data_write && (wr_count_q != '1)) begin
      wr_count_q <= wr_count_q + CNT_W'(1);
    end
  end

  // Read is asynchronous: a same-cycle write only becomes visible after the edge.
  assign datain      = dmem_q[ALUOutput];
  assign instruction = instruction_q;
  assign wr_count    = wr_count_q;
  assign running     = (state_q == StRun);
  assign load_ready  = (state_q == StLoad);

endmodule

// File: tb/tb_vsa_mem_responder.sv
module tb_vsa_mem_responder;

  localparam logic [11:0] Nop = 12'h600;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  PC;
  logic [11:0] instruction;
  logic [4:0]  ALUOutput;
  logic [4:0]  datain;
  logic [4:0]  dataout;
  logic        wr;
  logic        load_valid;
  logic        load_ready;
  logic [11:0] load_data;
  logic        load_last;
  logic        running;
  logic [7:0]  wr_count;

  always #5 clock = ~clock;

  vsa_mem_responder dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .PC          (PC),
    .instruction (instruction),
    .ALUOutput   (ALUOutput),
    .datain      (datain),
    .dataout     (dataout),
    .wr          (wr),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .running     (running),
    .wr_count    (wr_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: plain arrays and counters following the mode rules.
  logic [11:0] m_imem [32];
  logic [4:0]  m_dmem [32];
  bit          m_run;
  int          m_ptr;
  int          m_cnt;
  logic [11:0] m_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the effect of one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_imem[i] = Nop;
        m_dmem[i] = 5'd0;
      end
      m_run   = 1'b0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_instr = Nop;
    end else begin
      bit was_run;
      was_run = m_run;
      m_instr = was_run ? m_imem[PC] : Nop;
      if (!was_run && load_valid) begin
        m_imem[m_ptr] = load_data;
        m_ptr++;
        if (load_last || m_ptr == 32) m_run = 1'b1;
      end
      if (was_run && wr) begin
        m_dmem[ALUOutput] = dataout;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".instr"}, 32'(instruction), 32'(m_instr));
    check({where, ".running"}, 32'(running), 32'(m_run));
    check({where, ".ready"}, 32'(load_ready), 32'(!m_run));
    check({where, ".count"}, 32'(wr_count), 32'(m_cnt));
    check({where, ".datain"}, 32'(datain), 32'(m_dmem[ALUOutput]));
  endtask

  task automatic tick(input string where);
    model_edge();
    @(posedge clock);
    #1;
    compare_all(where);
  endtask

  task automatic idle();
    reset_n    = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 12'h000;
    wr         = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick("rst");
    reset_n = 1'b1;
  endtask

  initial begin
    int          accepts;
    logic [11:0] first_word;

    PC        = 5'd0;
    ALUOutput = 5'd0;
    dataout   = 5'd0;
    idle();

    // 1: reset state
    do_reset();
    check("t1.instr", 32'(instruction), 32'h600);
    check("t1.ready", 32'(load_ready), 32'd1);
    check("t1.running", 32'(running), 32'd0);
    check("t1.count", 32'(wr_count), 32'd0);
    for (int a = 0; a < 32; a += 9) begin
      ALUOutput = 5'(a);
      #1;
      check("t1.datain", 32'(datain), 32'd0);
    end

    // 2: short program ending on load_last
    load_valid = 1'b1;
    load_data = 12'h801; tick("t2.ld");
    load_data = 12'h212; tick("t2.ld");
    load_data = 12'h600; load_last = 1'b1; tick("t2.ld");
    idle();
    check("t2.running", 32'(running), 32'd1);
    PC = 5'd1; tick("t2.f"); tick("t2.f");
    check("t2.pc1", 32'(instruction), 32'h212);
    PC = 5'd3; tick("t2.f"); tick("t2.f");
    check("t2.pc3", 32'(instruction), 32'h600);
    PC = 5'd0; tick("t2.f"); tick("t2.f");
    check("t2.pc0", 32'(instruction), 32'h801);

    // 3: 32 words with toggling valid, no load_last
    do_reset();
    accepts = 0;
    first_word = 12'h000;
    while (accepts < 32) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 12'($urandom);
      if (load_valid && accepts == 0) first_word = load_data;
      tick("t3.ld");
      if (load_valid) accepts++;
    end
    check("t3.running", 32'(running), 32'd1);
    load_valid = 1'b1; load_data = 12'hABC; tick("t3.extra");
    idle();
    PC = 5'd0; tick("t3.f"); tick("t3.f");
    check("t3.imem0", 32'(instruction), 32'(first_word));

    // 4: data write in RUN, old value visible until the edge
    ALUOutput = 5'd5; dataout = 5'h1A; wr = 1'b1;
    #1;
    check("t4.pre", 32'(datain), 32'h00);
    tick("t4.wr");
    wr = 1'b0;
    #1;
    check("t4.post", 32'(datain), 32'h1A);
    check("t4.count", 32'(wr_count), 32'd1);

    // 5: writes during LOAD are ignored
    do_reset();
    ALUOutput = 5'd7; dataout = 5'h0F; wr = 1'b1;
    tick("t5.wr");
    wr = 1'b0;
    tick("t5.idle");
    check("t5.datain", 32'(datain), 32'd0);
    check("t5.count", 32'(wr_count), 32'd0);

    // 6: saturating counter, then reset mid-run
    load_valid = 1'b1; load_last = 1'b1; load_data = 12'h123;
    tick("t6.ld");
    idle();
    for (int n = 0; n < 300; n++) begin
      wr = 1'b1;
      ALUOutput = 5'($urandom);
      dataout = 5'($urandom);
      PC = 5'($urandom);
      tick("t6.wr");
    end
    wr = 1'b0;
    check("t6.sat", 32'(wr_count), 32'hFF);
    do_reset();
    check("t6.running", 32'(running), 32'd0);
    check("t6.count", 32'(wr_count), 32'd0);
    check("t6.instr", 32'(instruction), 32'h600);
    for (int a = 0; a < 32; a++) begin
      ALUOutput = 5'(a);
      #1;
      check("t6.clr", 32'(datain), 32'd0);
    end

    // Random traffic against the model, with occasional resets
    for (int n = 0; n < 1500; n++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      load_valid = 1'($urandom_range(0, 1));
      load_last  = ($urandom_range(0, 15) == 0);
      load_data  = 12'($urandom);
      wr         = 1'($urandom_range(0, 1));
      ALUOutput  = 5'($urandom);
      dataout    = 5'($urandom);
      PC         = 5'($urandom);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
